kws_post_smooth: RTL and testbench

Parametrised keyword-spotting post-processor; sits between the CNN output writer and the host/LED interface. Per frame it tracks the top-2 class scores over `NUM_CLASS` sequential writes and reports the winning index and margin. A temporal smoothing FSM then issues a keyword detection only when one non-background class wins with sufficient margin for `HOLD_FRAMES` consecutive frames. After each detection it applies a refractory window.

---
 rtl/kws_post_pkg.sv | 40 ++++
 rtl/kws_top2_tracker.sv | 98 +++++++++
 rtl/kws_post_smooth.sv | 157 +++++++++++++++
 tb/tb_kws_post_smooth.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kws_post_pkg.sv
// Shared definitions for the keyword-spotting post-processor:
// index-width helper, invalid-index constant, smoothing FSM states and
// the saturating subtract used by the signed build (KWS_POST_SIGNED_EN).
package kws_post_pkg;

    // Smoothing FSM states
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COUNT   = 2'd1,
        REFRACT = 2'd2
    } smooth_state_t;

    // Index width: one code beyond the last class is reserved for "no winner"
    function automatic int kws_iw(input int num_class);
        return $clog2(num_class + 1);
    endfunction

    // Invalid index; truncating -1 to any index width yields all ones
    localparam int IDX_INV = -1;

    // Working width of the saturating subtract (score widths up to 63 bits)
    localparam int SAT_W = 64;

    // a - b on sign-extended operands, clamped to [0, 2^dw-1]
    function automatic logic [SAT_W-1:0] sat_sub(input logic signed [SAT_W-1:0] a,
                                                 input logic signed [SAT_W-1:0] b,
                                                 input int dw);
        logic signed [SAT_W-1:0] d;
        logic signed [SAT_W-1:0] lim;
        d   = a - b;
        lim = (64'sd1 <<< dw) - 64'sd1;
        if (d < 0)
            sat_sub = '0;
        else if (d > lim)
            sat_sub = lim;
        else
            sat_sub = d;
    endfunction

endpackage

// File: rtl/kws_top2_tracker.sv
// Per-frame top-2 score tracker: counts score writes, keeps the largest and
// second-largest eligible scores with the index of the largest, and pulses
// 'closed' on the edge that accepts the last write of a frame.
// KWS_POST_SIGNED_EN selects signed scores (all eligible, trackers start at
// the most negative value); otherwise scores with the MSB set are ignored.
module kws_top2_tracker
    import kws_post_pkg::*;
#(
    parameter int NUM_CLASS = 7,
    parameter int DW        = 16,
    parameter int IW        = kws_iw(NUM_CLASS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          init,
    input  logic          we,
    input  logic [DW-1:0] dout,
    output logic [DW-1:0] max1,
    output logic [DW-1:0] max2,
    output logic [IW-1:0] idx,
    output logic          closed
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLASS - 1);
    localparam logic [IW-1:0] INV_IDX  = IW'(IDX_INV);
`ifdef KWS_POST_SIGNED_EN
    localparam logic [DW-1:0] TRK_INIT = {1'b1, {(DW-1){1'b0}}};
`else
    localparam logic [DW-1:0] TRK_INIT = '0;
`endif

    logic [IW-1:0] wcnt_reg;
    logic          done_reg;
    logic [DW-1:0] max1_reg;
    logic [DW-1:0] max2_reg;
    logic [IW-1:0] idx_reg;
    logic          closed_reg;

    logic accept;
    logic eligible;
    logic gt1;
    logic gt2;

    // Frame start wins over a simultaneous write; writes after close are dropped
    assign accept = we && !init && !done_reg;

`ifdef KWS_POST_SIGNED_EN
    assign eligible = 1'b1;
    assign gt1      = $signed(dout) > $signed(max1_reg);
    assign gt2      = $signed(dout) > $signed(max2_reg);
`else
    assign eligible = ~dout[DW-1];
    assign gt1      = dout > max1_reg;
    assign gt2      = dout > max2_reg;
`endif

    // Write counter, top-2 trackers and frame-close pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wcnt_reg   <= '0;
            done_reg   <= 1'b0;
            max1_reg   <= TRK_INIT;
            max2_reg   <= TRK_INIT;
            idx_reg    <= INV_IDX;
            closed_reg <= 1'b0;
        end else begin
            closed_reg <= 1'b0;
            if (init) begin
                wcnt_reg <= '0;
                done_reg <= 1'b0;
                max1_reg <= TRK_INIT;
                max2_reg <= TRK_INIT;
                idx_reg  <= INV_IDX;
            end else if (accept) begin
                // Strict compares: on a tie the earlier index keeps the lead
                if (eligible && gt1) begin
                    max2_reg <= max1_reg;
                    max1_reg <= dout;
                    idx_reg  <= wcnt_reg;
                end else if (eligible && gt2) begin
                    max2_reg <= dout;
                end
                if (wcnt_reg == LAST_IDX) begin
                    done_reg   <= 1'b1;
                    closed_reg <= 1'b1;
                end else begin
                    wcnt_reg <= wcnt_reg + 1'b1;
                end
            end
        end
    end

    assign max1   = max1_reg;
    assign max2   = max2_reg;
    assign idx    = idx_reg;
    assign closed = closed_reg;

endmodule

// File: rtl/kws_post_smooth.sv
// Keyword-spotting post-processor: per-frame winner/margin reporting plus a
// temporal smoothing FSM that detects a non-background class winning with
// enough margin for HOLD_FRAMES consecutive frames, followed by a
// REFRACT_FRAMES dead window. KWS_POST_SIGNED_EN selects signed scores.
module kws_post_smooth
    import kws_post_pkg::*;
#(
    parameter int NUM_CLASS      = 7,
    parameter int DW             = 16,
    parameter int IW             = kws_iw(NUM_CLASS),
    parameter int BG_IDX         = 0,
    parameter int HOLD_FRAMES    = 3,
    parameter int REFRACT_FRAMES = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_init,
    input  logic          i_we,
    input  logic [DW-1:0] i_dout,
    input  logic [DW-1:0] i_thresh,
    output logic [DW-1:0] o_diff,
    output logic [IW-1:0] o_max_idx,
    output logic          o_validp,
    output logic [IW-1:0] o_det_idx,
    output logic          o_detp
);

    localparam logic [IW-1:0] INV_IDX = IW'(IDX_INV);
    localparam logic [IW-1:0] BG_CLS  = IW'(BG_IDX);
    localparam logic [3:0]    HOLD_C  = 4'(HOLD_FRAMES);
    localparam logic [3:0]    REFR_C  = 4'(REFRACT_FRAMES);

    logic [DW-1:0] max1;
    logic [DW-1:0] max2;
    logic [IW-1:0] idx;
    logic          closed;

    logic [DW-1:0] diff_now;
    logic          qual_now;
    logic          qual_reg;

    smooth_state_t state_reg;
    logic [IW-1:0] cand_reg;
    logic [3:0]    cnt_reg;
    logic [3:0]    rcnt_reg;
    logic          det_fire;

    kws_top2_tracker #(
        .NUM_CLASS (NUM_CLASS),
        .DW        (DW),
        .IW        (IW)
    ) u_tracker (
        .clk    (clk),
        .resetn (resetn),
        .init   (i_init),
        .we     (i_we),
        .dout   (i_dout),
        .max1   (max1),
        .max2   (max2),
        .idx    (idx),
        .closed (closed)
    );

`ifdef KWS_POST_SIGNED_EN
    logic [SAT_W-1:0] diff_wide;
    assign diff_wide = sat_sub({{(SAT_W-DW){max1[DW-1]}}, max1},
                               {{(SAT_W-DW){max2[DW-1]}}, max2}, DW);
    assign diff_now  = diff_wide[DW-1:0];
`else
    // max1 >= max2 whenever both hold eligible (MSB-clear) values
    assign diff_now = max1 - max2;
`endif

    assign qual_now = (idx != INV_IDX) && (idx != BG_CLS) && (diff_now >= i_thresh);

    // Frame result registers, loaded the cycle after the closing write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_diff    <= '0;
            o_max_idx <= INV_IDX;
            o_validp  <= 1'b0;
            qual_reg  <= 1'b0;
        end else begin
            o_validp <= closed;
            if (closed) begin
                o_diff    <= diff_now;
                o_max_idx <= idx;
                qual_reg  <= qual_now;
            end
        end
    end

    // Detection condition for the frame result currently presented
    always_comb begin
        det_fire = 1'b0;
        if (o_validp && qual_reg) begin
            if (state_reg == HUNT)
                det_fire = (HOLD_C == 4'd1);
            else if (state_reg == COUNT)
                det_fire = (o_max_idx == cand_reg) && (cnt_reg + 4'd1 == HOLD_C);
        end
    end

    // Smoothing FSM, stepped once per frame result
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= HUNT;
            cand_reg  <= INV_IDX;
            cnt_reg   <= '0;
            rcnt_reg  <= '0;
            o_det_idx <= INV_IDX;
            o_detp    <= 1'b0;
        end else begin
            o_detp <= 1'b0;
            if (det_fire) begin
                o_detp    <= 1'b1;
                o_det_idx <= o_max_idx;
                cand_reg  <= o_max_idx;
                cnt_reg   <= '0;
                if (REFR_C != 4'd0) begin
                    state_reg <= REFRACT;
                    rcnt_reg  <= REFR_C;
                end else begin
                    state_reg <= HUNT;
                end
            end else if (o_validp) begin
                case (state_reg)
                    HUNT: begin
                        if (qual_reg) begin
                            cand_reg  <= o_max_idx;
                            cnt_reg   <= 4'd1;
                            state_reg <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (!qual_reg) begin
                            cnt_reg   <= '0;
                            state_reg <= HUNT;
                        end else if (o_max_idx != cand_reg) begin
                            cand_reg <= o_max_idx;
                            cnt_reg  <= 4'd1;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end
                    REFRACT: begin
                        rcnt_reg <= rcnt_reg - 4'd1;
                        if (rcnt_reg <= 4'd1)
                            state_reg <= HUNT;
                    end
                    default: state_reg <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kws_post_smooth.sv
// Scoreboard bench for kws_post_smooth (HOLD=3, REFRACT=2). Frames are driven
// by a stimulus process that computes the expected frame result and
// detection from a reference model and queues them; a monitor pops and
// compares whenever the DUT presents a frame result.
module tb_kws_post_smooth;

    localparam int NC   = 7;
    localparam int DW   = 16;
    localparam int IW   = 3;
    localparam int BG   = 0;
    localparam int HOLD = 3;
    localparam int REFR = 2;
    localparam logic [IW-1:0] INV = '1;
`ifdef KWS_POST_SIGNED_EN
    localparam int TRK_INIT_V = -(1 << (DW-1));
`else
    localparam int TRK_INIT_V = 0;
`endif

    typedef logic [NC-1:0][DW-1:0] frame_t;
    typedef struct {
        int            cyc;
        logic [DW-1:0] diff;
        logic [IW-1:0] idx;
        bit            det;
        logic [IW-1:0] det_idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          i_init = 1'b0;
    logic          i_we = 1'b0;
    logic [DW-1:0] i_dout = '0;
    logic [DW-1:0] i_thresh = 16'd10;
    logic [DW-1:0] o_diff;
    logic [IW-1:0] o_max_idx;
    logic          o_validp;
    logic [IW-1:0] o_det_idx;
    logic          o_detp;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t exp_q[$];

    // Reference model of the smoothing behaviour
    int hist[$];
    int last_det = -1 - REFR;
    logic [IW-1:0] model_det_idx = '1;

    kws_post_smooth #(
        .NUM_CLASS      (NC),
        .DW             (DW),
        .IW             (IW),
        .BG_IDX         (BG),
        .HOLD_FRAMES    (HOLD),
        .REFRACT_FRAMES (REFR)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_init    (i_init),
        .i_we      (i_we),
        .i_dout    (i_dout),
        .i_thresh  (i_thresh),
        .o_diff    (o_diff),
        .o_max_idx (o_max_idx),
        .o_validp  (o_validp),
        .o_det_idx (o_det_idx),
        .o_detp    (o_detp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void score_val(input logic [DW-1:0] x, output int v, output bit elig);
`ifdef KWS_POST_SIGNED_EN
        v    = int'($signed(x));
        elig = 1'b1;
`else
        v    = int'(x);
        elig = !x[DW-1];
`endif
    endfunction

    // Frame result: top-2 of the eligible scores together with two copies of
    // the tracker start value; winner is the earliest index holding the top
    // value, provided it beats the start value.
    function automatic void model_frame(input frame_t s, output logic [DW-1:0] d,
                                        output logic [IW-1:0] ix);
        int vals[$];
        int v, top1, top2, pos, dd;
        bit elig;
        vals.push_back(TRK_INIT_V);
        vals.push_back(TRK_INIT_V);
        for (int k = 0; k < NC; k++) begin
            score_val(s[k], v, elig);
            if (elig) vals.push_back(v);
        end
        top1 = vals[0];
        pos  = 0;
        for (int j = 1; j < vals.size(); j++)
            if (vals[j] > top1) begin
                top1 = vals[j];
                pos  = j;
            end
        vals.delete(pos);
        top2 = vals[0];
        for (int j = 1; j < vals.size(); j++)
            if (vals[j] > top2) top2 = vals[j];
        ix = INV;
        for (int k = NC - 1; k >= 0; k--) begin
            score_val(s[k], v, elig);
            if (elig && v == top1 && top1 > TRK_INIT_V) ix = IW'(k);
        end
        dd = top1 - top2;
        d  = (dd > (1 << DW) - 1) ? '1 : DW'(dd);
    endfunction

    function automatic frame_t mk(input int a0, input int a1, input int a2, input int a3,
                                  input int a4, input int a5, input int a6);
        frame_t f;
        f[0] = DW'(a0); f[1] = DW'(a1); f[2] = DW'(a2); f[3] = DW'(a3);
        f[4] = DW'(a4); f[5] = DW'(a5); f[6] = DW'(a6);
        return f;
    endfunction

    // Frame won by 'win' with the given margin over the runner-up
    function automatic frame_t make_win(input int win, input int margin);
        frame_t f;
        int other;
        for (int k = 0; k < NC; k++) f[k] = DW'($urandom_range(0, 150));
        other    = (win + 1 + int'($urandom_range(0, NC - 2))) % NC;
        f[other] = DW'(200);
        f[win]   = DW'(200 + margin);
        return f;
    endfunction

    // Drive one frame, queue its expected result and detection outcome
    task automatic run_frame(input frame_t s, input bit collide, input bit gaps);
        logic [DW-1:0] d;
        logic [IW-1:0] ix;
        bit q, det;
        int n, run;
        exp_t e;
        i_init = 1'b1;
        if (collide) begin
            i_we   = 1'b1;
            i_dout = DW'($urandom);
        end
        step();
        i_init = 1'b0;
        i_we   = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            i_we   = 1'b1;
            i_dout = s[k];
            step();
            i_we = 1'b0;
        end
        model_frame(s, d, ix);
        q = (ix != INV) && (ix != IW'(BG)) && (d >= i_thresh);
        hist.push_back(q ? int'(ix) : -1);
        n   = hist.size() - 1;
        run = 0;
        for (int j = n; j > last_det + REFR && j >= 0; j--) begin
            if (hist[n] >= 0 && hist[j] == hist[n]) run++;
            else break;
        end
        det = (run == HOLD);
        if (det) begin
            last_det      = n;
            model_det_idx = ix;
        end
        e.cyc     = cyc + 1;
        e.diff    = d;
        e.idx     = ix;
        e.det     = det;
        e.det_idx = model_det_idx;
        exp_q.push_back(e);
        if ($urandom_range(0, 3) == 0) begin
            i_we   = 1'b1;
            i_dout = DW'($urandom);
            step();
            i_we = 1'b0;
        end
        repeat (3) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_diff"}, 32'(o_diff), 32'd0);
        chk({tag, "_max_idx"}, 32'(o_max_idx), 32'(INV));
        chk({tag, "_validp"}, 32'(o_validp), 32'd0);
        chk({tag, "_det_idx"}, 32'(o_det_idx), 32'(INV));
        chk({tag, "_detp"}, 32'(o_detp), 32'd0);
    endtask

    // Monitor: compare every presented frame result and the detection slot after it
    initial begin : monitor
        exp_t e;
        exp_t de;
        int det_due;
        det_due = -1;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                det_due = -1;
            end else begin
                if (det_due == cyc) begin
                    chk("detp", 32'(o_detp), 32'(de.det));
                    chk("det_idx", 32'(o_det_idx), 32'(de.det_idx));
                    if (de.det) $display("detect cyc=%0d class=%0d", cyc, o_det_idx);
                    det_due = -1;
                end else if (o_detp !== 1'b0) begin
                    chk("unexpected_detp", 32'(o_detp), 32'd0);
                end
                if (o_validp === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_validp", 32'(o_validp), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                        chk("diff", 32'(o_diff), 32'(e.diff));
                        chk("max_idx", 32'(o_max_idx), 32'(e.idx));
                        $display("frame cyc=%0d idx=%0d diff=%0d", cyc, o_max_idx, o_diff);
                        de      = e;
                        det_due = cyc + 1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        repeat (3) step();
        check_reset_outputs("reset");
        resetn = 1'b1;
        step();

        run_frame(mk(10, 50, 30, 0, 0, 0, 0), 1'b0, 1'b0);
        run_frame(mk(-5, -3, -9, -100, -7, -8, -6), 1'b0, 1'b1);
        run_frame(mk(40, 40, 0, 0, 0, 0, 0), 1'b1, 1'b0);
        run_frame(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);

        // Persistent class 2: detection, refractory window, detection again
        for (int i = 0; i < 8; i++)
            run_frame(make_win(2, 20), 1'(i % 2), 1'($urandom_range(0, 1)));
        run_frame(mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);

        // Winner changes: 2,2,4,4,4
        run_frame(make_win(2, 20), 1'b0, 1'b0);
        run_frame(make_win(2, 20), 1'b0, 1'b0);
        repeat (3) run_frame(make_win(4, 20), 1'b0, 1'b0);

        // Run broken by a low-margin frame, then by a background winner
        run_frame(make_win(2, 20), 1'b0, 1'b0);
        run_frame(make_win(2, 20), 1'b0, 1'b0);
        run_frame(make_win(2, 5), 1'b0, 1'b0);
        run_frame(make_win(2, 20), 1'b0, 1'b0);
        run_frame(make_win(2, 20), 1'b0, 1'b0);
        run_frame(make_win(BG, 30), 1'b0, 1'b0);

        // Reset during COUNT and mid-frame
        run_frame(make_win(2, 20), 1'b0, 1'b0);
        run_frame(make_win(2, 20), 1'b0, 1'b0);
        i_init = 1'b1;
        step();
        i_init = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_we   = 1'b1;
            i_dout = DW'(300 + k);
            step();
        end
        i_we = 1'b0;
        #2 resetn = 1'b0;
        #1 check_reset_outputs("midreset");
        hist.delete();
        last_det      = -1 - REFR;
        model_det_idx = INV;
        repeat (2) step();
        resetn = 1'b1;
        step();
        run_frame(make_win(2, 20), 1'b0, 1'b0);
        run_frame(make_win(2, 20), 1'b0, 1'b0);

        // Randomised frames
        for (int i = 0; i < 40; i++) begin
            i_thresh = DW'($urandom_range(5, 20));
            if ($urandom_range(0, 3) == 0) begin
                frame_t f;
                for (int k = 0; k < NC; k++) f[k] = DW'($urandom);
                run_frame(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NC - 1))
                                                : 2 + int'($urandom_range(0, 1));
                run_frame(make_win(w, int'($urandom_range(0, 30))),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        repeat (6) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
